// File: rtl/spi_slave_sync.sv
// SPI slave with clk-domain synchronizers: receives and transmits one
// M-bit word per LOAD-low frame, MSB first, SCLK idle low.
module spi_slave_sync #(
  parameter int unsigned M    = 15,
  parameter int unsigned SYNC = 2
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         LOAD,
  input  logic         SCLK,
  input  logic         MOSI,
  input  logic [M-1:0] DI,
  output logic         MISO,
  output logic [M-1:0] DO,
  output logic         rx_valid,
  output logic         tx_ack,
  output logic         frm_err,
  output logic [M-1:0] sr_STX,
  output logic [M-1:0] sr_SRX,
  output logic [4:0]   cb_bit
);

  localparam int unsigned CW = 5;
  localparam logic [CW-1:0] FULL = CW'(M);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [SYNC:0]   sclk_q, load_q, rdy_q;
  logic [SYNC-1:0] mosi_q;
  logic            pend_q, pend_n;
  logic [M-1:0]    stx_n, srx_n, do_n;
  logic [CW-1:0]   cnt_n;
  logic            rxv_n, ack_n, fe_n;

  logic sclk_rise, sclk_fall, load_rise, load_fall, mosi_s, ready;

  // Synchronizer chains; the extra stage on SCLK/LOAD feeds edge detection.
  // rdy_q masks the LOAD edge that the reset values would fake after release.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sclk_q <= '0;
      load_q <= '1;
      mosi_q <= '0;
      rdy_q  <= '0;
    end else begin
      sclk_q <= {sclk_q[SYNC-1:0], SCLK};
      load_q <= {load_q[SYNC-1:0], LOAD};
      mosi_q <= {mosi_q[SYNC-2:0], MOSI};
      rdy_q  <= {rdy_q[SYNC-1:0], 1'b1};
    end
  end

  assign ready     = rdy_q[SYNC];
  assign mosi_s    = mosi_q[SYNC-1];
  assign sclk_rise =  sclk_q[SYNC-1] & ~sclk_q[SYNC];
  assign sclk_fall = ~sclk_q[SYNC-1] &  sclk_q[SYNC];
  assign load_rise =  load_q[SYNC-1] & ~load_q[SYNC];
  assign load_fall = ~load_q[SYNC-1] &  load_q[SYNC] & ready;

  assign MISO = sr_STX[M-1];

  // State, shift registers, counter and output pulses.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      sr_STX   <= '0;
      sr_SRX   <= '0;
      cb_bit   <= '0;
      DO       <= '0;
      pend_q   <= 1'b0;
      rx_valid <= 1'b0;
      tx_ack   <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      state    <= state_n;
      sr_STX   <= stx_n;
      sr_SRX   <= srx_n;
      cb_bit   <= cnt_n;
      DO       <= do_n;
      pend_q   <= pend_n;
      rx_valid <= rxv_n;
      tx_ack   <= ack_n;
      frm_err  <= fe_n;
    end
  end

  // Next-state and datapath decisions; SCLK edges are applied before a
  // same-cycle LOAD rise closes the frame.
  always_comb begin
    state_n = state;
    stx_n   = sr_STX;
    srx_n   = sr_SRX;
    cnt_n   = cb_bit;
    do_n    = DO;
    pend_n  = pend_q;
    rxv_n   = 1'b0;
    ack_n   = 1'b0;
    fe_n    = 1'b0;
    case (state)
      IDLE: begin
        if (load_fall || pend_q) begin
          stx_n   = DI;
          srx_n   = '0;
          cnt_n   = '0;
          ack_n   = 1'b1;
          pend_n  = 1'b0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise && (cb_bit < FULL)) begin
          srx_n = {sr_SRX[M-2:0], mosi_s};
          cnt_n = cb_bit + CW'(1);
        end
        if (sclk_fall && (cb_bit < FULL)) begin
          stx_n = {sr_STX[M-2:0], 1'b0};
        end
        if (load_rise) begin
          state_n = DONE;
        end
      end
      DONE: begin
        if (cb_bit == FULL) begin
          do_n  = sr_SRX;
          rxv_n = 1'b1;
        end else begin
          fe_n = 1'b1;
        end
        if (load_fall) begin
          pend_n = 1'b1;
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: a bit-banged SPI master at clk/8 and a
// word-level model of what each frame should deliver.
module tb_spi_slave_sync;

  localparam int unsigned M    = 15;
  localparam int unsigned SYNC = 2;

  logic         clk, clr, LOAD, SCLK, MOSI;
  logic [M-1:0] DI, DO, sr_STX, sr_SRX;
  logic         MISO, rx_valid, tx_ack, frm_err;
  logic [4:0]   cb_bit;

  int n_vec = 0;
  int n_err = 0;
  int cnt_rx = 0, cnt_tx = 0, cnt_fe = 0, dbl = 0;
  bit prev_rx = 0, prev_tx = 0, prev_fe = 0;
  logic [M-1:0] model_do = '0;

  spi_slave_sync #(.M(M), .SYNC(SYNC)) dut (
    .clk(clk), .clr(clr), .LOAD(LOAD), .SCLK(SCLK), .MOSI(MOSI), .DI(DI),
    .MISO(MISO), .DO(DO), .rx_valid(rx_valid), .tx_ack(tx_ack),
    .frm_err(frm_err), .sr_STX(sr_STX), .sr_SRX(sr_SRX), .cb_bit(cb_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters and detection of any pulse lasting two cycles.
  always @(negedge clk) begin
    if (rx_valid) cnt_rx++;
    if (tx_ack)   cnt_tx++;
    if (frm_err)  cnt_fe++;
    if ((rx_valid && prev_rx) || (tx_ack && prev_tx) || (frm_err && prev_fe)) dbl++;
    prev_rx = rx_valid;
    prev_tx = tx_ack;
    prev_fe = frm_err;
  end

  // One master frame: n SCLK pulses, MOSI beyond bit M is 'fill'. With
  // collide the LOAD rise coincides with the last SCLK rise. LOAD stays
  // high for 'gap' cycles; lat is the cycle count to rx_valid/frm_err.
  task automatic send_frame(input logic [M-1:0] di, input logic [M-1:0] word,
                            input int n, input bit fill, input int gap,
                            input bit collide, output logic [M-1:0] rx,
                            output int lat);
    int idx;
    rx   = '0;
    lat  = 99;
    DI   = di;
    LOAD = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      idx  = int'(M) - 1 - i;
      MOSI = (i < int'(M)) ? word[idx] : fill;
      repeat (4) @(negedge clk);
      if (i < int'(M)) rx[idx] = MISO;
      SCLK = 1'b1;
      if (i == 0) DI = ~di;
      if (collide && i == n - 1) begin
        LOAD = 1'b1;
      end else begin
        repeat (4) @(negedge clk);
        SCLK = 1'b0;
      end
    end
    if (!collide) begin
      repeat (4) @(negedge clk);
      LOAD = 1'b1;
    end
    for (int c = 1; c <= gap; c++) begin
      @(negedge clk);
      if (lat == 99 && (rx_valid || frm_err)) lat = c;
      if (c == 4) SCLK = 1'b0;
    end
    SCLK = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; LOAD = 1'b1; SCLK = 1'b0; MOSI = 1'b0; DI = '0;
    repeat (3) @(negedge clk);
    n_vec++; if (DO !== '0) begin n_err++; $display("FAIL reset_do: got %h want 0", DO); end
    n_vec++; if (sr_STX !== '0) begin n_err++; $display("FAIL reset_stx: got %h want 0", sr_STX); end
    n_vec++; if (sr_SRX !== '0) begin n_err++; $display("FAIL reset_srx: got %h want 0", sr_SRX); end
    n_vec++; if (cb_bit !== 5'd0) begin n_err++; $display("FAIL reset_cb: got %0d want 0", cb_bit); end
    n_vec++; if (MISO !== 1'b0) begin n_err++; $display("FAIL reset_miso: got %b want 0", MISO); end
    n_vec++;
    if ({rx_valid, tx_ack, frm_err} !== 3'b000) begin
      n_err++; $display("FAIL reset_pulses: got %b want 000", {rx_valid, tx_ack, frm_err});
    end
    clr = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [M-1:0] rx; int lat; int r0, t0, f0;
    r0 = cnt_rx; t0 = cnt_tx; f0 = cnt_fe;
    send_frame(15'h2AB5, 15'h1234, int'(M), 1'b0, 12, 1'b0, rx, lat);
    model_do = 15'h1234;
    n_vec++; if (DO !== model_do) begin n_err++; $display("FAIL basic_do: got %h want %h", DO, model_do); end
    n_vec++; if (rx !== 15'h2AB5) begin n_err++; $display("FAIL basic_miso: got %h want 2ab5", rx); end
    n_vec++; if (cnt_rx - r0 != 1) begin n_err++; $display("FAIL basic_rxv: got %0d pulses want 1", cnt_rx - r0); end
    n_vec++; if (cnt_tx - t0 != 1) begin n_err++; $display("FAIL basic_ack: got %0d pulses want 1", cnt_tx - t0); end
    n_vec++; if (cnt_fe != f0) begin n_err++; $display("FAIL basic_fe: got %0d pulses want 0", cnt_fe - f0); end
    n_vec++; if (lat > int'(SYNC) + 3) begin n_err++; $display("FAIL basic_lat: got %0d want <= %0d", lat, SYNC + 3); end
  endtask

  task automatic test_short();
    logic [M-1:0] rx; int lat; int r0, f0;
    r0 = cnt_rx; f0 = cnt_fe;
    send_frame(15'h0F0F, 15'h5555, 10, 1'b0, 12, 1'b0, rx, lat);
    n_vec++; if (cnt_fe - f0 != 1) begin n_err++; $display("FAIL short_fe: got %0d pulses want 1", cnt_fe - f0); end
    n_vec++; if (cnt_rx != r0) begin n_err++; $display("FAIL short_rxv: got %0d pulses want 0", cnt_rx - r0); end
    n_vec++; if (DO !== model_do) begin n_err++; $display("FAIL short_do: got %h want %h", DO, model_do); end
    n_vec++; if (cb_bit !== 5'd10) begin n_err++; $display("FAIL short_cb: got %0d want 10", cb_bit); end
    n_vec++; if (lat > int'(SYNC) + 3) begin n_err++; $display("FAIL short_lat: got %0d want <= %0d", lat, SYNC + 3); end
  endtask

  task automatic test_long();
    logic [M-1:0] rx; int lat; int r0;
    r0 = cnt_rx;
    send_frame(15'h1357, 15'h7FFF, 18, 1'b1, 12, 1'b0, rx, lat);
    model_do = 15'h7FFF;
    n_vec++; if (cb_bit !== 5'd15) begin n_err++; $display("FAIL long_cb: got %0d want 15", cb_bit); end
    n_vec++; if (DO !== model_do) begin n_err++; $display("FAIL long_do: got %h want 7fff", DO); end
    n_vec++; if (cnt_rx - r0 != 1) begin n_err++; $display("FAIL long_rxv: got %0d pulses want 1", cnt_rx - r0); end
    n_vec++; if (rx !== 15'h1357) begin n_err++; $display("FAIL long_miso: got %h want 1357", rx); end
  endtask

  task automatic test_collide();
    logic [M-1:0] rx; int lat; int r0;
    r0 = cnt_rx;
    send_frame(15'h6C3A, 15'h2468, int'(M), 1'b0, 12, 1'b1, rx, lat);
    model_do = 15'h2468;
    n_vec++; if (DO !== model_do) begin n_err++; $display("FAIL collide_do: got %h want 2468", DO); end
    n_vec++; if (cnt_rx - r0 != 1) begin n_err++; $display("FAIL collide_rxv: got %0d pulses want 1", cnt_rx - r0); end
  endtask

  task automatic test_clr_abort();
    logic [M-1:0] rx; int lat; int r0, t0, f0;
    DI = 15'h3C3C; LOAD = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      MOSI = 1'($urandom);
      repeat (4) @(negedge clk); SCLK = 1'b1;
      repeat (4) @(negedge clk); SCLK = 1'b0;
    end
    clr = 1'b1;
    repeat (2) @(negedge clk);
    r0 = cnt_rx; t0 = cnt_tx; f0 = cnt_fe;
    n_vec++; if (DO !== '0) begin n_err++; $display("FAIL clr_do: got %h want 0", DO); end
    n_vec++; if (sr_STX !== '0 || sr_SRX !== '0) begin n_err++; $display("FAIL clr_sr: got %h/%h want 0/0", sr_STX, sr_SRX); end
    n_vec++; if (cb_bit !== 5'd0 || MISO !== 1'b0) begin n_err++; $display("FAIL clr_cb_miso: got %0d/%b want 0/0", cb_bit, MISO); end
    clr = 1'b0;
    model_do = '0;
    repeat (10) @(negedge clk);
    n_vec++; if (cnt_tx != t0) begin n_err++; $display("FAIL clr_nostart: got %0d tx_ack want 0", cnt_tx - t0); end
    LOAD = 1'b1;
    repeat (12) @(negedge clk);
    n_vec++;
    if (cnt_rx != r0 || cnt_fe != f0) begin
      n_err++; $display("FAIL clr_nopulse: got rx %0d fe %0d want 0 0", cnt_rx - r0, cnt_fe - f0);
    end
    send_frame(15'h1111, 15'h0F0F, int'(M), 1'b0, 12, 1'b0, rx, lat);
    model_do = 15'h0F0F;
    n_vec++; if (DO !== model_do) begin n_err++; $display("FAIL clr_next_do: got %h want 0f0f", DO); end
  endtask

  task automatic test_back_to_back();
    logic [M-1:0] rx; int lat; int r0, t0;
    r0 = cnt_rx; t0 = cnt_tx;
    send_frame(15'h0AAA, 15'h0001, int'(M), 1'b0, 5, 1'b0, rx, lat);
    n_vec++; if (DO !== 15'h0001) begin n_err++; $display("FAIL b2b_do1: got %h want 0001", DO); end
    send_frame(15'h5001, 15'h4000, int'(M), 1'b0, 12, 1'b0, rx, lat);
    model_do = 15'h4000;
    n_vec++; if (DO !== model_do) begin n_err++; $display("FAIL b2b_do2: got %h want 4000", DO); end
    n_vec++; if (rx !== 15'h5001) begin n_err++; $display("FAIL b2b_miso: got %h want 5001", rx); end
    n_vec++; if (cnt_rx - r0 != 2) begin n_err++; $display("FAIL b2b_rxv: got %0d pulses want 2", cnt_rx - r0); end
    n_vec++; if (cnt_tx - t0 != 2) begin n_err++; $display("FAIL b2b_ack: got %0d pulses want 2", cnt_tx - t0); end
  endtask

  // LOAD high for a single cycle: the new frame start lands in DONE.
  task automatic test_pending();
    logic [M-1:0] rx; int lat; int r0, t0;
    r0 = cnt_rx; t0 = cnt_tx;
    send_frame(15'h0123, 15'h7531, int'(M), 1'b0, 1, 1'b0, rx, lat);
    send_frame(15'h4567, 15'h1ACE, int'(M), 1'b0, 12, 1'b0, rx, lat);
    model_do = 15'h1ACE;
    n_vec++; if (DO !== model_do) begin n_err++; $display("FAIL pend_do: got %h want 1ace", DO); end
    n_vec++; if (rx !== 15'h4567) begin n_err++; $display("FAIL pend_miso: got %h want 4567", rx); end
    n_vec++; if (cnt_rx - r0 != 2 || cnt_tx - t0 != 2) begin
      n_err++; $display("FAIL pend_pulses: got rx %0d ack %0d want 2 2", cnt_rx - r0, cnt_tx - t0);
    end
  endtask

  task automatic test_random();
    logic [M-1:0] rx, di, word; int lat, n, sel, r0, t0, f0, exp_cb;
    bit fill, col;
    for (int k = 0; k < 16; k++) begin
      di = M'($urandom); word = M'($urandom);
      sel = int'($urandom_range(0, 3));
      n = (sel < 2) ? int'(M) : (sel == 2) ? int'($urandom_range(1, M - 1)) : int'($urandom_range(M + 1, M + 4));
      fill = 1'($urandom); col = 1'($urandom);
      r0 = cnt_rx; t0 = cnt_tx; f0 = cnt_fe;
      send_frame(di, word, n, fill, int'($urandom_range(5, 12)), col, rx, lat);
      if (n >= int'(M)) model_do = word;
      exp_cb = (n < int'(M)) ? n : int'(M);
      n_vec++; if (DO !== model_do) begin n_err++; $display("FAIL rnd%0d_do: got %h want %h", k, DO, model_do); end
      n_vec++; if (int'(cb_bit) != exp_cb) begin n_err++; $display("FAIL rnd%0d_cb: got %0d want %0d", k, cb_bit, exp_cb); end
      n_vec++;
      if (cnt_rx - r0 != int'(n >= int'(M)) || cnt_fe - f0 != int'(n < int'(M)) || cnt_tx - t0 != 1) begin
        n_err++; $display("FAIL rnd%0d_pulses: got rx %0d fe %0d ack %0d for %0d bits", k, cnt_rx - r0, cnt_fe - f0, cnt_tx - t0, n);
      end
      n_vec++; if (lat > int'(SYNC) + 3) begin n_err++; $display("FAIL rnd%0d_lat: got %0d want <= %0d", k, lat, SYNC + 3); end
      if (n >= int'(M)) begin
        n_vec++; if (rx !== di) begin n_err++; $display("FAIL rnd%0d_miso: got %h want %h", k, rx, di); end
      end
    end
  endtask

  task automatic test_pulse_shape();
    n_vec++; if (dbl != 0) begin n_err++; $display("FAIL pulse_width: got %0d two-cycle pulses want 0", dbl); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_long();
    test_collide();
    test_clr_abort();
    test_back_to_back();
    test_pending();
    test_random();
    test_pulse_shape();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
